// File: rtl/uart_apb_bridge_pkg.sv
// Shared types and protocol constants for the UART-to-APB debug bridge.
package uart_apb_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StSetup,
    StAccess,
    StResp
  } state_e;

  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] STAT_ACK  = 8'h06;
  localparam logic [7:0] STAT_NAK  = 8'h15;

endpackage

// File: rtl/uart_apb_bridge_if.sv
// Byte streams, APB master bus and busy flag of the bridge; master = bridge side.
interface uart_apb_bridge_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        apbm_psel;
  logic        apbm_penable;
  logic        apbm_pwrite;
  logic [15:0] apbm_paddr;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata;
  logic        apbm_pready;
  logic        apbm_pslverr;
  logic        busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, apbm_prdata, apbm_pready, apbm_pslverr,
    output rx_ready, tx_data, tx_valid, apbm_psel, apbm_penable, apbm_pwrite,
    output apbm_paddr, apbm_pwdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, apbm_prdata, apbm_pready, apbm_pslverr,
    input  rx_ready, tx_data, tx_valid, apbm_psel, apbm_penable, apbm_pwrite,
    input  apbm_paddr, apbm_pwdata, busy
  );

endinterface

// File: rtl/uart_apb_bridge_timeout.sv
// Inter-byte inactivity counter; o_expired holds once TIMEOUT idle cycles have elapsed.
module uart_apb_bridge_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_count;
  logic            w_at_limit;

  assign w_at_limit = (r_count == CntW'(TIMEOUT));
  assign o_expired  = w_at_limit;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (!w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_bridge.sv
// UART byte-stream to APB master debug bridge (read/write frames, ACK/NAK status).
// Optional inter-byte timeout enabled by defining UART_APB_BRIDGE_TIMEOUT_EN.
module uart_apb_bridge
  import uart_apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  uart_apb_bridge_if.master   bus
);

  state_e      r_state;
  logic [1:0]  r_cnt;
  logic        r_last;
  logic        r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [15:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_status;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_expired;
  logic [1:0]  w_next_cnt;
  logic [7:0]  w_status;

  assign w_rx_ready = !i_rst && (r_state inside {StIdle, StAddr, StWdata});
  assign w_rx_fire  = w_rx_ready && bus.rx_valid;
  assign w_next_cnt = r_cnt + 2'd1;
  assign w_status   = bus.apbm_pslverr ? STAT_NAK : STAT_ACK;

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  logic w_to_clear;
  assign w_to_clear = w_rx_fire || !(r_state inside {StAddr, StWdata});

  uart_apb_bridge_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_to_clear),
    .o_expired (w_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign w_expired      = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= 2'd0;
      r_last     <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= 16'h0000;
      r_pwdata   <= 32'h0;
      r_rdata    <= 32'h0;
      r_status   <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Unknown command bytes are swallowed so the host can resync.
          if (w_rx_fire && (bus.rx_data == CMD_READ || bus.rx_data == CMD_WRITE)) begin
            r_pwrite <= (bus.rx_data == CMD_WRITE);
            r_cnt    <= 2'd0;
            r_state  <= StAddr;
          end
        end
        StAddr: begin
          if (w_rx_fire) begin
            if (r_cnt == 2'd0) begin
              r_paddr[7:0] <= bus.rx_data;
              r_cnt        <= 2'd1;
            end else begin
              r_paddr[15:8] <= bus.rx_data;
              r_cnt         <= 2'd0;
              if (r_pwrite) begin
                r_state <= StWdata;
              end else begin
                r_psel  <= 1'b1;
                r_state <= StSetup;
              end
            end
          end else if (w_expired) begin
            r_state <= StIdle;
          end
        end
        StWdata: begin
          if (w_rx_fire) begin
            r_pwdata[{r_cnt, 3'b000} +: 8] <= bus.rx_data;
            r_cnt <= w_next_cnt;
            if (r_cnt == 2'd3) begin
              r_psel  <= 1'b1;
              r_state <= StSetup;
            end
          end else if (w_expired) begin
            r_state <= StIdle;
          end
        end
        StSetup: begin
          r_penable <= 1'b1;
          r_state   <= StAccess;
        end
        StAccess: begin
          if (bus.apbm_pready) begin
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_rdata    <= bus.apbm_prdata;
            r_status   <= w_status;
            r_tx_valid <= 1'b1;
            r_tx_data  <= r_pwrite ? w_status : bus.apbm_prdata[7:0];
            r_last     <= r_pwrite;
            r_cnt      <= 2'd0;
            r_state    <= StResp;
          end
        end
        StResp: begin
          if (bus.tx_ready) begin
            if (r_last) begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_last     <= 1'b0;
              r_state    <= StIdle;
            end else if (r_cnt == 2'd3) begin
              r_tx_data <= r_status;
              r_last    <= 1'b1;
            end else begin
              r_cnt     <= w_next_cnt;
              r_tx_data <= r_rdata[{w_next_cnt, 3'b000} +: 8];
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rx_ready     = w_rx_ready;
  assign bus.tx_data      = r_tx_data;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.apbm_psel    = r_psel;
  assign bus.apbm_penable = r_penable;
  assign bus.apbm_pwrite  = r_pwrite;
  assign bus.apbm_paddr   = r_paddr;
  assign bus.apbm_pwdata  = r_pwdata;
  assign bus.busy         = (r_state != StIdle);

endmodule

// File: tb/tb_uart_apb_bridge.sv
// Directed self-checking bench for uart_apb_bridge with a simple APB slave model.
module tb_uart_apb_bridge;

`ifdef UART_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned TbTimeout = 100;
`else
  localparam int unsigned TbTimeout = 50000;
`endif

  logic clk;
  logic rst;

  uart_apb_bridge_if bus_if ();

  uart_apb_bridge #(
    .TIMEOUT (TbTimeout)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // APB slave model knobs and observations
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err   = 1'b0;
  int          acc_len   = 0;
  int          last_acc_len = 0;
  int          n_setup   = 0;
  int          stab_err  = 0;
  logic [15:0] cap_addr  = 16'h0;
  logic        cap_write = 1'b0;
  logic [31:0] cap_wdata = 32'h0;
  logic [7:0]  tx_q[$];

  initial begin
    bus_if.apbm_pready  = 1'b0;
    bus_if.apbm_prdata  = 32'h0;
    bus_if.apbm_pslverr = 1'b0;
  end

  always @(negedge clk) begin
    if (bus_if.apbm_psel && bus_if.apbm_penable) begin
      acc_len++;
      if (bus_if.apbm_paddr !== cap_addr || bus_if.apbm_pwrite !== cap_write ||
          bus_if.apbm_pwdata !== cap_wdata)
        stab_err++;
      bus_if.apbm_pready = (acc_len > slv_wait);
      bus_if.apbm_prdata  = bus_if.apbm_pready ? slv_rdata : 32'h0;
      bus_if.apbm_pslverr = bus_if.apbm_pready ? slv_err : 1'b0;
      if (bus_if.apbm_pready) last_acc_len = acc_len;
    end else begin
      acc_len = 0;
      bus_if.apbm_pready  = 1'b0;
      bus_if.apbm_prdata  = 32'h0;
      bus_if.apbm_pslverr = 1'b0;
      if (bus_if.apbm_psel === 1'b1) begin
        n_setup++;
        cap_addr  = bus_if.apbm_paddr;
        cap_write = bus_if.apbm_pwrite;
        cap_wdata = bus_if.apbm_pwdata;
      end
    end
    if (!rst && bus_if.tx_valid === 1'b1 && bus_if.tx_ready === 1'b1) tx_q.push_back(bus_if.tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (bus_if.rx_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_byte_%02h: rx_ready stayed %b, required 1", b, bus_if.rx_ready);
    end
    @(posedge clk); #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int nbytes);
    int n = 0;
    while ((tx_q.size() < nbytes || bus_if.busy !== 1'b0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL wait_idle: got %0d tx bytes busy=%b, required %0d bytes busy=0",
               tx_q.size(), bus_if.busy, nbytes);
    end
  endtask

  task automatic check_tx(input string name, input logic [7:0] exp[5], input int n);
    n_tests++;
    if (tx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s_count: got %0d tx bytes, required %0d", name, tx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (tx_q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, tx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus_if.rx_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_rx_ready: got %b, required 0", bus_if.rx_ready);
    end
    n_tests++;
    if ({bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite} !== 3'b000 ||
        bus_if.apbm_paddr !== 16'h0 || bus_if.apbm_pwdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_apb: got sel=%b en=%b wr=%b addr=%h wdata=%h, required all 0",
               bus_if.apbm_psel, bus_if.apbm_penable, bus_if.apbm_pwrite,
               bus_if.apbm_paddr, bus_if.apbm_pwdata);
    end
    n_tests++;
    if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tx_busy: got tx_valid=%b tx_data=%h busy=%b, required 0 00 0",
               bus_if.tx_valid, bus_if.tx_data, bus_if.busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (bus_if.rx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_rx_ready: got %b, required 1", bus_if.rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    logic [7:0] exp[5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h06};
    tx_q.delete(); n_setup = 0; stab_err = 0;
    slv_wait = 0; slv_rdata = 32'hDEADBEEF; slv_err = 1'b0;
    send_byte(8'h52); send_byte(8'h34); send_byte(8'h12);
    n_tests++;
    if (bus_if.apbm_psel !== 1'b1 || bus_if.apbm_penable !== 1'b0 || bus_if.rx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read_setup: got sel=%b en=%b rx_ready=%b, required 1 0 0",
               bus_if.apbm_psel, bus_if.apbm_penable, bus_if.rx_ready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus_if.apbm_psel !== 1'b1 || bus_if.apbm_penable !== 1'b1) begin
      n_fail++;
      $display("FAIL read_access: got sel=%b en=%b, required 1 1",
               bus_if.apbm_psel, bus_if.apbm_penable);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'hEF) begin
      n_fail++;
      $display("FAIL read_latency: got tx_valid=%b tx_data=%h, required 1 EF",
               bus_if.tx_valid, bus_if.tx_data);
    end
    wait_idle(5);
    n_tests++;
    if (cap_addr !== 16'h1234 || cap_write !== 1'b0 || n_setup != 1 || stab_err != 0) begin
      n_fail++;
      $display("FAIL read_apb: got addr=%h wr=%b setups=%0d unstable=%0d, required 1234 0 1 0",
               cap_addr, cap_write, n_setup, stab_err);
    end
    check_tx("read", exp, 5);
  endtask

  task automatic test_write();
    logic [7:0] exp[5] = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_q.delete(); n_setup = 0; stab_err = 0;
    slv_wait = 3; slv_err = 1'b0;
    send_byte(8'h57); send_byte(8'h08); send_byte(8'h00);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    wait_idle(1);
    n_tests++;
    if (cap_wdata !== 32'h12345678 || cap_addr !== 16'h0008 || cap_write !== 1'b1) begin
      n_fail++;
      $display("FAIL write_apb: got addr=%h wr=%b wdata=%h, required 0008 1 12345678",
               cap_addr, cap_write, cap_wdata);
    end
    n_tests++;
    if (last_acc_len != 4 || stab_err != 0 || n_setup != 1) begin
      n_fail++;
      $display("FAIL write_access: got len=%0d unstable=%0d setups=%0d, required 4 0 1",
               last_acc_len, stab_err, n_setup);
    end
    check_tx("write", exp, 1);
  endtask

  task automatic test_error();
    logic [7:0] exp[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h15};
    tx_q.delete();
    slv_wait = 1; slv_rdata = 32'h0; slv_err = 1'b1;
    send_byte(8'h52); send_byte(8'h40); send_byte(8'h00);
    wait_idle(5);
    check_tx("error", exp, 5);
    slv_err = 1'b0;
  endtask

  task automatic test_resync();
    logic [7:0] exp[5] = '{8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h06};
    tx_q.delete(); n_setup = 0;
    slv_wait = 0; slv_rdata = 32'h0C0D0E0F;
    send_byte(8'h00);
    send_byte(8'hFF);
    n_tests++;
    if (bus_if.busy !== 1'b0) begin
      n_fail++; $display("FAIL resync_idle: got busy=%b, required 0", bus_if.busy);
    end
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    wait_idle(5);
    n_tests++;
    if (n_setup != 1 || cap_addr !== 16'h0100 || cap_write !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_apb: got setups=%0d addr=%h wr=%b, required 1 0100 0",
               n_setup, cap_addr, cap_write);
    end
    check_tx("resync", exp, 5);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[5] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h06};
    int n = 0;
    int changes = 0;
    tx_q.delete();
    slv_wait = 0; slv_rdata = 32'h11223344;
    bus_if.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h10); send_byte(8'h20);
    while (bus_if.tx_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus_if.tx_data !== 8'h44 || bus_if.tx_valid !== 1'b1) changes++;
    end
    n_tests++;
    if (changes != 0 || n >= 20) begin
      n_fail++;
      $display("FAIL backpressure_hold: got %0d unstable cycles tx_data=%h, required 0 and 44",
               changes, bus_if.tx_data);
    end
    bus_if.tx_ready = 1'b1;
    wait_idle(5);
    check_tx("backpressure", exp, 5);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    tx_q.delete();
    slv_wait = 20; slv_rdata = 32'hCAFEF00D;
    send_byte(8'h52); send_byte(8'h22); send_byte(8'h33);
    while (!(bus_if.apbm_psel === 1'b1 && bus_if.apbm_penable === 1'b1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (bus_if.apbm_psel !== 1'b0 || bus_if.apbm_penable !== 1'b0 || n >= 20) begin
      n_fail++;
      $display("FAIL reset_mid_psel: got sel=%b en=%b, required 0 0",
               bus_if.apbm_psel, bus_if.apbm_penable);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_tests++;
    if (tx_q.size() != 0 || bus_if.busy !== 1'b0 || bus_if.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_resp: got %0d tx bytes busy=%b, required 0 bytes busy=0",
               tx_q.size(), bus_if.busy);
    end
    slv_wait = 0;
  endtask

  task automatic test_timeout();
    tx_q.delete(); n_setup = 0;
    slv_wait = 0; slv_rdata = 32'h01020304;
    send_byte(8'h57); send_byte(8'h08);
    repeat (101) @(posedge clk);
    #1;
`ifdef UART_APB_BRIDGE_TIMEOUT_EN
    begin
      logic [7:0] exp[5] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h06};
      n_tests++;
      if (bus_if.busy !== 1'b0) begin
        n_fail++; $display("FAIL timeout_abort: got busy=%b, required 0", bus_if.busy);
      end
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
      wait_idle(5);
      n_tests++;
      if (n_setup != 1 || cap_write !== 1'b0 || cap_addr !== 16'h0000) begin
        n_fail++;
        $display("FAIL timeout_apb: got setups=%0d wr=%b addr=%h, required 1 0 0000",
                 n_setup, cap_write, cap_addr);
      end
      check_tx("timeout", exp, 5);
    end
`else
    begin
      logic [7:0] exp[5] = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
      n_tests++;
      if (bus_if.busy !== 1'b1 || n_setup != 0) begin
        n_fail++;
        $display("FAIL no_timeout_wait: got busy=%b setups=%0d, required 1 0",
                 bus_if.busy, n_setup);
      end
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
      send_byte(8'h03); send_byte(8'h04);
      wait_idle(1);
      n_tests++;
      if (n_setup != 1 || cap_write !== 1'b1 || cap_addr !== 16'h0008 ||
          cap_wdata !== 32'h04030201) begin
        n_fail++;
        $display("FAIL no_timeout_apb: got setups=%0d wr=%b addr=%h wdata=%h, required 1 1 0008 04030201",
                 n_setup, cap_write, cap_addr, cap_wdata);
      end
      check_tx("no_timeout", exp, 1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_error();
    test_resync();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

Debug bridge sitting directly downstream of the UART receive byte stream and upstream of its transmit byte stream. Parses a minimal binary command protocol from received bytes and performs single 32-bit APB master transfers on the peripheral bus. Returns read data and transfer status as response bytes. Gives host-side bus access over the serial link without CPU involvement.

## Interface
Parameters:
- `TIMEOUT`, 50000: inactivity limit in `clk` cycles between bytes of one frame; only used when `UART_APB_BRIDGE_TIMEOUT_EN` is defined.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  bridge accepts a byte this cycle.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  downstream accepts `tx_data`.
- `apbm_psel`, `apbm_penable`, `apbm_pwrite`  out  1 each  APB master controls.
- `apbm_paddr`  out  16  APB address.
- `apbm_pwdata`  out  32  APB write data.
- `apbm_prdata`  in  32  APB read data.
- `apbm_pready`, `apbm_pslverr`  in  1 each  APB completion and error.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Frame layout:
  - Byte 0 is the command: 0x52 'R' = read, 0x57 'W' = write.
  - Bytes 1–2 are the address, low byte first.
  - A write frame then carries 4 data bytes, LSB first.
- Any other command byte is consumed and discarded. The bridge stays in IDLE, which allows host resync.
- `apbm_paddr` is `{addr_hi, addr_lo}`, passed unmodified with no alignment forcing.
- State machine:
  - IDLE → ADDR (on a valid command byte).
  - ADDR takes 2 bytes, then → WDATA if write, → SETUP if read.
  - WDATA takes 4 bytes → SETUP.
  - SETUP → ACCESS.
  - ACCESS holds until `apbm_pready` → RESP.
  - RESP → IDLE after the last response byte is accepted.
- A 2-bit byte counter is shared by ADDR, WDATA and RESP.
- Read response: 4 bytes of `prdata` (captured at the `pready` cycle), LSB first, then one status byte.
- Write response: one status byte only.
- Status byte: 0x06 ACK if `pslverr` = 0, 0x15 NAK if `pslverr` = 1. Read data bytes are still sent on error.
- Reset values:
  - all APB outputs 0;
  - `tx_valid` 0, `tx_data` 0x00;
  - `busy` 0;
  - state IDLE, counters 0.
- `rx_ready` is 0 while `rst` is high.
- Reset asserted mid-frame or mid-APB-transfer abandons the transfer immediately: `psel`/`penable` drop on the next edge and no response is sent.

## Timing
- Handshakes:
  - A byte transfers on `rx_valid && rx_ready`.
  - `rx_ready` = 1 exactly in IDLE, ADDR and WDATA.
- APB sequence:
  - SETUP is entered on the edge following the last frame byte accepted.
  - SETUP lasts 1 cycle: `psel` = 1, `penable` = 0.
  - ACCESS: `psel` = `penable` = 1, held until `pready` is sampled high.
  - `paddr`, `pwrite` and `pwdata` stay stable from SETUP through ACCESS.
- `tx_valid` asserts on the cycle after the `pready` edge.
- `tx_data` is held stable while `tx_valid && !tx_ready`. The next byte is presented on the cycle after each accept.
- Minimum read latency is 2 cycles from the last frame byte to `tx_valid`, with zero-wait-state APB.
- `rx_valid` during SETUP/ACCESS/RESP is not accepted; back-pressure is held.

## Configuration
- `UART_APB_BRIDGE_TIMEOUT_EN` defined:
  - A counter clears on every accepted byte and increments each cycle in ADDR or WDATA.
  - When the counter reaches `TIMEOUT`, the partial frame is discarded and the state returns to IDLE. No APB transfer and no response occur.
  - Counter width is `$clog2(TIMEOUT+1)`.
- Macro undefined: no counter exists, and a partial frame waits indefinitely.

## Structure
- Package `uart_apb_bridge_pkg` holds:
  - state enum;
  - command constants `CMD_READ` = 8'h52, `CMD_WRITE` = 8'h57;
  - status constants `STAT_ACK` = 8'h06, `STAT_NAK` = 8'h15.
- One sub-module: `uart_apb_bridge_timeout` (the inactivity counter), instantiated only under the macro.

## Test plan
- Read: send 52 34 12, slave returns DEADBEEF with pready on 1st ACCESS cycle → `paddr` = 0x1234, `pwrite` = 0; tx bytes EF BE AD DE 06.
- Write: send 57 08 00 78 56 34 12, pready after 3 wait cycles → `pwdata` = 0x12345678, ACCESS lasts 4 cycles; tx byte 06.
- Error: read with `pslverr` = 1 and `prdata` = 0 → tx 00 00 00 00 15.
- Resync: send 00 FF 52 00 01 → first two bytes dropped, single read at `paddr` 0x0100.
- Back-pressure and reset: `tx_ready` low 5 cycles → `tx_data` stable; `rst` asserted during ACCESS → `psel` 0 next cycle, no tx bytes.
- Timeout: with macro defined and `TIMEOUT` = 100, send 57 08 then idle 101 cycles, then 52 00 00 → no write occurs, read at 0x0000 responds normally.
